// File: rtl/alsu_arbiter.sv
// Round-robin arbiter and beat sequencer that shares one ALSU between NUM_REQ requesters.
// Screens illegal commands, preloads shift operands, and samples alsu_out at a fixed latency.
module alsu_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int IDW          = $clog2(NUM_REQ),
  parameter int CMD_W        = 16,
  parameter int ALSU_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [CMD_W*NUM_REQ-1:0] req_cmd,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [5:0]               rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [2:0]               alsu_a,
  output logic [2:0]               alsu_b,
  output logic [2:0]               alsu_opcode,
  output logic                     alsu_cin,
  output logic                     alsu_red_op_a,
  output logic                     alsu_red_op_b,
  output logic                     alsu_bypass_a,
  output logic                     alsu_bypass_b,
  output logic                     alsu_direction,
  output logic                     alsu_serial_in,
  input  logic [5:0]               alsu_out
);

  typedef struct packed {
    logic       serial_in;
    logic       direction;
    logic       bypass_b;
    logic       bypass_a;
    logic       red_op_b;
    logic       red_op_a;
    logic       cin;
    logic [2:0] opcode;
    logic [2:0] b;
    logic [2:0] a;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int CNT_W = (ALSU_LATENCY > 1) ? $clog2(ALSU_LATENCY) : 1;

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       data_q, data_d;
  logic             err_q, err_d;

  cmd_t             req_cmds [NUM_REQ];
  cmd_t             grant_cmd;
  cmd_t             pins;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic             grant_bypass;
  logic             grant_bad;
  logic             grant_shift;
  logic             cur_shift;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_cmds[i] = cmd_t'(req_cmd[i*CMD_W +: $bits(cmd_t)]);
    end
  end

  // Search upward starting one past the last served requester; first hit wins.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path can infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(last_grant_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_cmd    = req_cmds[grant_idx];
  assign grant_bypass = grant_cmd.bypass_a | grant_cmd.bypass_b;
  assign grant_bad    = ((grant_cmd.red_op_a | grant_cmd.red_op_b) &
                         (grant_cmd.opcode[1] | grant_cmd.opcode[2])) |
                        (grant_cmd.opcode[2] & grant_cmd.opcode[1]);
  assign grant_shift  = !grant_bypass &&
                        (grant_cmd.opcode == 3'd4 || grant_cmd.opcode == 3'd5);
  assign cur_shift    = !(cmd_q.bypass_a | cmd_q.bypass_b) &&
                        (cmd_q.opcode == 3'd4 || cmd_q.opcode == 3'd5);

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    err_d        = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          cmd_d = grant_cmd;
          id_d  = grant_idx;
          if (grant_bad && !grant_bypass) begin
            state_d = S_RESP;
            data_d  = '0;
            err_d   = 1'b1;
          end else if (grant_shift) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(ALSU_LATENCY - 1)) begin
          state_d = S_RESP;
          data_d  = alsu_out;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        // Fairness pointer only advances once the response has been taken.
        if (rsp_ready) begin
          state_d      = S_IDLE;
          last_grant_d = id_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      id_q         <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      cnt_q        <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found && rst_n) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Shift ops act on the ALSU's previous result, so LOAD parks the operand there via bypass_a.
  always_comb begin
    pins = '0;
    if (state_q == S_LOAD) begin
      pins.bypass_a = 1'b1;
      pins.a        = cmd_q.a;
    end else if (state_q == S_ISSUE) begin
      if (cur_shift) begin
        pins.opcode    = cmd_q.opcode;
        pins.direction = cmd_q.direction;
        pins.serial_in = cmd_q.serial_in;
      end else begin
        pins = cmd_q;
      end
    end
  end

  assign alsu_a         = pins.a;
  assign alsu_b         = pins.b;
  assign alsu_opcode    = pins.opcode;
  assign alsu_cin       = pins.cin;
  assign alsu_red_op_a  = pins.red_op_a;
  assign alsu_red_op_b  = pins.red_op_b;
  assign alsu_bypass_a  = pins.bypass_a;
  assign alsu_bypass_b  = pins.bypass_b;
  assign alsu_direction = pins.direction;
  assign alsu_serial_in = pins.serial_in;

  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alsu_arbiter.sv
// Bench for alsu_arbiter: a two-stage ALSU model closes the loop, a scoreboard tracks responses.
module tb_alsu_arbiter;

  localparam int NUM_REQ = 2;
  localparam int IDW     = 1;
  localparam int CMD_W   = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [CMD_W*NUM_REQ-1:0] req_cmd;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [5:0]               rsp_data;
  logic                     rsp_err;
  logic                     busy;
  logic [2:0]               alsu_a, alsu_b, alsu_opcode;
  logic                     alsu_cin, alsu_red_op_a, alsu_red_op_b;
  logic                     alsu_bypass_a, alsu_bypass_b, alsu_direction, alsu_serial_in;
  logic [5:0]               alsu_out;
  logic [15:0]              pins;

  always #5 clk = ~clk;

  alsu_arbiter #(
    .NUM_REQ(NUM_REQ), .IDW(IDW), .CMD_W(CMD_W), .ALSU_LATENCY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .alsu_a(alsu_a), .alsu_b(alsu_b), .alsu_opcode(alsu_opcode),
    .alsu_cin(alsu_cin), .alsu_red_op_a(alsu_red_op_a), .alsu_red_op_b(alsu_red_op_b),
    .alsu_bypass_a(alsu_bypass_a), .alsu_bypass_b(alsu_bypass_b),
    .alsu_direction(alsu_direction), .alsu_serial_in(alsu_serial_in),
    .alsu_out(alsu_out)
  );

  // Pins gathered in the same bit layout as a command word.
  assign pins = {alsu_serial_in, alsu_direction, alsu_bypass_b, alsu_bypass_a,
                 alsu_red_op_b, alsu_red_op_a, alsu_cin, alsu_opcode, alsu_b, alsu_a};

  // flags = {serial_in, direction, bypass_b, bypass_a, red_op_b, red_op_a, cin}
  function automatic logic [15:0] mk_cmd(input logic [2:0] a, input logic [2:0] b,
                                         input logic [2:0] op, input logic [6:0] flags);
    return {flags, op, b, a};
  endfunction

  // Behavioural ALSU: inputs registered, result registered (two cycles issue-to-result).
  function automatic logic [5:0] alsu_f(input logic [15:0] p, input logic [5:0] prev);
    logic [5:0] sa, sbv;
    sa  = {{3{p[2]}}, p[2:0]};
    sbv = {{3{p[5]}}, p[5:3]};
    if (p[12]) return sa;
    if (p[13]) return sbv;
    case (p[8:6])
      3'd0: return p[10] ? {5'b0, &p[2:0]} : (p[11] ? {5'b0, &p[5:3]} : (sa & sbv));
      3'd1: return p[10] ? {5'b0, ^p[2:0]} : (p[11] ? {5'b0, ^p[5:3]} : (sa ^ sbv));
      3'd2: return sa + sbv + {5'b0, p[9]};
      3'd3: return sa * sbv;
      3'd4: return p[14] ? {prev[4:0], p[15]} : {p[15], prev[5:1]};
      3'd5: return p[14] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
      default: return 6'd0;
    endcase
  endfunction

  logic [15:0] alsu_in_q;
  logic [5:0]  alsu_out_q;
  always @(posedge clk) begin
    if (!rst_n) begin
      alsu_in_q  <= '0;
      alsu_out_q <= '0;
    end else begin
      alsu_in_q  <= pins;
      alsu_out_q <= alsu_f(alsu_in_q, alsu_out_q);
    end
  end
  assign alsu_out = alsu_out_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         id;
    logic [5:0] data;
    logic       err;
    int         lat;
    int         gcyc;
  } sb_t;

  sb_t        scb[$];
  int         grant_log[$];
  logic [5:0] pend_data [NUM_REQ];
  logic       pend_err  [NUM_REQ];
  int         pend_lat  [NUM_REQ];
  logic       rsp_seen = 1'b0;

  // Grants push the requester's expected response; handshakes pop and compare.
  initial begin : monitor
    int  gid;
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rsp_seen = 1'b0;
      end else begin
        if (req_ready != '0) begin
          check("grant_onehot", $countones(req_ready), 1);
          gid = 0;
          for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gid = i;
          check("grant_was_valid", req_valid[gid], 1);
          e.id   = gid;
          e.data = pend_data[gid];
          e.err  = pend_err[gid];
          e.lat  = pend_lat[gid];
          e.gcyc = cyc;
          scb.push_back(e);
          grant_log.push_back(gid);
        end
        if (rsp_valid && !rsp_seen) begin
          rsp_seen = 1'b1;
          check("rsp_has_owner", scb.size() > 0, 1);
          if (scb.size() > 0) check("rsp_latency", cyc - scb[0].gcyc, scb[0].lat);
        end
        if (rsp_valid && rsp_ready) begin
          check("hs_has_owner", scb.size() > 0, 1);
          if (scb.size() > 0) begin
            e = scb.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_data", rsp_data, e.data);
            check("rsp_err", rsp_err, e.err);
          end
          rsp_seen = 1'b0;
        end
      end
    end
  end

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [15:0] cmd, input logic [5:0] d,
                         input logic e, input int lat);
    pend_data[id] = d;
    pend_err[id]  = e;
    pend_lat[id]  = lat;
    req_cmd[id*CMD_W +: CMD_W] = cmd;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (grant_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("grant_wait", grant_log.size() >= n, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || scb.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", !busy && scb.size() == 0, 1);
  endtask

  logic [15:0] c_rr0, c_rr1, c_add, c_shl, c_load, c_shi, c_bad, c_byp, c_bp0, c_bp1;
  int base;

  initial begin
    c_rr0  = mk_cmd(3'b110, 3'd3, 3'd3, 7'b0000000);
    c_rr1  = mk_cmd(3'd1, 3'd1, 3'd3, 7'b0000000);
    c_add  = mk_cmd(3'd3, 3'd2, 3'd2, 7'b0000001);
    c_shl  = mk_cmd(3'b011, 3'd0, 3'd4, 7'b1100000);
    c_load = mk_cmd(3'b011, 3'd0, 3'd0, 7'b0001000);
    c_shi  = mk_cmd(3'd0, 3'd0, 3'd4, 7'b1100000);
    c_bad  = mk_cmd(3'd1, 3'd1, 3'd6, 7'b0000000);
    c_byp  = mk_cmd(3'd1, 3'd1, 3'd6, 7'b0001000);
    c_bp0  = mk_cmd(3'd1, 3'd1, 3'd2, 7'b0000000);
    c_bp1  = mk_cmd(3'd1, 3'd2, 3'd2, 7'b0000000);

    rst_n     = 1'b0;
    req_valid = '0;
    req_cmd   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy, pins}, 0);
    drive_slot();
    rst_n = 1'b1;

    // Round-robin: both requesters hold valid; requester 0 first after reset.
    drive_slot();
    base = grant_log.size();
    set_req(0, c_rr0, 6'b111010, 1'b0, 4);
    set_req(1, c_rr1, 6'd1, 1'b0, 4);
    wait_grants(base + 4, 40);
    drive_slot();
    req_valid = '0;
    wait_idle(40);
    if (grant_log.size() >= base + 4)
      for (int i = 0; i < 4; i++) check("rr_order", grant_log[base+i], i % 2);

    // Single add: 3 + 2 + cin = 6.
    drive_slot();
    set_req(0, c_add, 6'd6, 1'b0, 4);
    @(negedge clk);
    check("add_grant", req_ready, 2'b01);
    drive_slot();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("add_issue_pins", pins, c_add);
    wait_idle(20);

    // Shift left with serial_in=1 after preloading a=3.
    drive_slot();
    set_req(0, c_shl, 6'b000111, 1'b0, 5);
    @(negedge clk);
    check("shift_grant", req_ready, 2'b01);
    drive_slot();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("shift_load_pins", pins, c_load);
    drive_slot();
    @(negedge clk);
    check("shift_issue_pins", pins, c_shi);
    wait_idle(20);

    // Invalid opcode 6: rejected in one cycle, ALSU pins never move.
    drive_slot();
    set_req(0, c_bad, 6'd0, 1'b1, 1);
    @(negedge clk);
    check("bad_grant", req_ready, 2'b01);
    check("bad_pins_g0", pins, 0);
    drive_slot();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("bad_pins_g1", pins, 0);
    check("bad_rsp_valid", rsp_valid, 1);
    drive_slot();
    @(negedge clk);
    check("bad_pins_g2", pins, 0);
    wait_idle(20);

    // Same opcode with bypass_a is legal and returns a.
    drive_slot();
    set_req(0, c_byp, 6'd1, 1'b0, 4);
    @(negedge clk);
    check("byp_grant", req_ready, 2'b01);
    drive_slot();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("byp_issue_pins", pins, c_byp);
    wait_idle(20);

    // Back-pressure: response held while requester 1 waits.
    drive_slot();
    rsp_ready = 1'b0;
    set_req(0, c_bp0, 6'd2, 1'b0, 4);
    @(negedge clk);
    check("bp_grant0", req_ready, 2'b01);
    drive_slot();
    req_valid[0] = 1'b0;
    set_req(1, c_bp1, 6'd3, 1'b0, 4);
    begin
      int k = 0;
      while (!rsp_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
    end
    check("bp_rsp_rise", rsp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      drive_slot();
      @(negedge clk);
      check("bp_hold", {rsp_valid, rsp_id, rsp_data, rsp_err, busy, req_ready},
            {1'b1, 1'b0, 6'd2, 1'b0, 1'b1, 2'b00});
    end
    drive_slot();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake", rsp_valid, 1);
    drive_slot();
    @(negedge clk);
    check("bp_grant1", req_ready, 2'b10);
    drive_slot();
    req_valid[1] = 1'b0;
    wait_idle(20);

    // Reset during WAIT: command discarded, requester 0 first afterwards.
    drive_slot();
    set_req(0, c_add, 6'd6, 1'b0, 4);
    @(negedge clk);
    check("pre_grant", req_ready, 2'b01);
    drive_slot();
    req_valid[0] = 1'b0;
    wait_idle(20);
    drive_slot();
    set_req(0, c_add, 6'd6, 1'b0, 4);
    @(negedge clk);
    check("mid_grant", req_ready, 2'b01);
    drive_slot();
    req_valid[0] = 1'b0;
    drive_slot();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 1);
    @(negedge clk);
    check("mid_reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy, pins}, 0);
    scb.delete();
    drive_slot();
    set_req(0, c_add, 6'd6, 1'b0, 4);
    set_req(1, c_bp1, 6'd3, 1'b0, 4);
    base = grant_log.size();
    drive_slot();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_grant", req_ready, 2'b01);
    wait_grants(base + 2, 20);
    drive_slot();
    req_valid = '0;
    wait_idle(30);
    if (grant_log.size() >= base + 2) check("post_reset_second", grant_log[base+1], 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
